// File: rtl/rapcore_spi_controller.sv
// rapcore_spi_controller
//   Wishbone slave that shifts 32-bit words out over an SPI link (mode 0,
//   MSB first) to the rapcore peripheral port while capturing the returned
//   word. CTRL.keep_cs chains several words inside one chip-select frame.
//
//   Register map (wbs_adr_i[3:2]):
//     0 CTRL    rw  {lpbk[9], keep_cs[8], div[DIV_WIDTH-1:0]}
//     1 TXDATA  wo  writing starts a word (reads return 0)
//     2 RXDATA  ro  last completed received word
//     3 STATUS  rw1c-ish {ovr[2], done[1], busy[0]}; write 1 to bit2/bit1 clears
//
//   SPI_LOOPBACK_EN: when defined, CTRL.lpbk exists and routes the internal
//   COPI back into the receive sampler. When undefined, bit 9 reads 0.
//
//   DIV_WIDTH must not exceed 8 so div stays inside CTRL byte 0.

module rapcore_spi_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DIV_WIDTH = 8,
    parameter int          DIV_RESET = 3
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_copi,
    input  logic        spi_cipo,
    output logic        busy
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] ctrl_div;
    logic                 ctrl_keep_cs;
    logic                 lpbk_bit;
    logic                 done;
    logic                 ovr;
    logic [31:0]          rx_data;

    // ------------------------------------------------------------------
    // SPI engine state
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;
    logic [DIV_WIDTH-1:0] hcnt;
    logic [DIV_WIDTH-1:0] frame_div;
    logic [4:0]           bit_cnt;
    logic [31:0]          tx_sr;
    logic [31:0]          rx_sr;
    logic                 rx_in;

    // FSM strobes consumed by the datapath
    logic start_frame;
    logic hcnt_load;
    logic hcnt_dec;
    logic sck_rise;
    logic sck_fall;
    logic word_done;
    logic cs_release;
    logic hcnt_zero;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic        wb_req;
    logic [1:0]  reg_sel;
    logic [31:0] wmask;
    logic        wr_ctrl;
    logic        wr_tx;
    logic        wr_status;
    logic        tx_accept;
    logic        tx_overrun;
    logic [31:0] ctrl_word;
    logic [31:0] rd_word;
    logic        unused_adr_bits;

    // Byte address bits below the word offset carry no information here.
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
                   & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = wbs_adr_i[3:2];
    assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign wr_ctrl    = wb_req & wbs_we_i & (reg_sel == REG_CTRL);
    assign wr_tx      = wb_req & wbs_we_i & (reg_sel == REG_TXDATA) & (|wbs_sel_i);
    assign wr_status  = wb_req & wbs_we_i & (reg_sel == REG_STATUS);
    assign tx_accept  = wr_tx & ~busy;
    assign tx_overrun = wr_tx & busy;

`ifdef SPI_LOOPBACK_EN
    logic ctrl_lpbk;
    assign lpbk_bit = ctrl_lpbk;
`else
    assign lpbk_bit = 1'b0;
`endif

    // Receive source: internal COPI in loopback, otherwise the CIPO pad.
    assign rx_in = lpbk_bit ? spi_copi : spi_cipo;

    // Assemble the CTRL view from its fields.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first so no path leaves it unassigned and infers a latch.
        ctrl_word                  = '0;
        ctrl_word[DIV_WIDTH-1:0]   = ctrl_div;
        ctrl_word[8]               = ctrl_keep_cs;
        ctrl_word[9]               = lpbk_bit;
    end

    // Read data mux; TXDATA is write-only and reads as zero.
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_CTRL:   rd_word = ctrl_word;
            REG_TXDATA: rd_word = '0;
            REG_RXDATA: rd_word = rx_data;
            REG_STATUS: rd_word = {29'd0, ovr, done, busy};
            default:    rd_word = '0;
        endcase
    end

    // Wishbone handshake: one-cycle ack the cycle after a request, data only with ack.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: reset is synchronous (sampled on the clock edge) and all
        // sequential state uses non-blocking assignments.
        if (!resetn) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req & ~wbs_we_i) ? rd_word : 32'd0;
        end
    end

    // Control and status registers, including the frame busy/done/overrun flags.
    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            ctrl_div     <= DIV_WIDTH'(DIV_RESET);
            ctrl_keep_cs <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            ctrl_lpbk    <= 1'b0;
`endif
            busy         <= 1'b0;
            done         <= 1'b0;
            ovr          <= 1'b0;
            rx_data      <= '0;
        end else begin
            if (wr_ctrl) begin
                if (wbs_sel_i[0]) ctrl_div     <= wbs_dat_i[DIV_WIDTH-1:0];
                if (wbs_sel_i[1]) ctrl_keep_cs <= wbs_dat_i[8];
`ifdef SPI_LOOPBACK_EN
                if (wbs_sel_i[1]) ctrl_lpbk    <= wbs_dat_i[9];
`endif
            end

            if (tx_accept) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (word_done) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                rx_data <= rx_sr;
            end

            if (tx_overrun) begin
                ovr <= 1'b1;
            end

            if (wr_status && wbs_sel_i[0]) begin
                if (wbs_dat_i[2]) ovr <= 1'b0;
                if (wbs_dat_i[1]) done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI framing FSM
    // ------------------------------------------------------------------
    assign hcnt_zero = (hcnt == '0);

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        hcnt_load   = 1'b0;
        hcnt_dec    = 1'b0;
        sck_rise    = 1'b0;
        sck_fall    = 1'b0;
        word_done   = 1'b0;
        cs_release  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending word starts at once inside an open frame; otherwise
                // it waits until CS has been high for a full half period.
                if (busy && (!spi_cs_n || hcnt_zero)) begin
                    start_frame = 1'b1;
                    state_d     = ST_SETUP;
                end else if (!spi_cs_n && !ctrl_keep_cs) begin
                    hcnt_load = 1'b1;
                    state_d   = ST_HOLD;
                end else if (!hcnt_zero) begin
                    hcnt_dec = 1'b1;
                end
            end

            ST_SETUP: begin
                if (hcnt_zero) begin
                    sck_rise  = 1'b1;
                    hcnt_load = 1'b1;
                    state_d   = ST_XFER;
                end else begin
                    hcnt_dec = 1'b1;
                end
            end

            ST_XFER: begin
                if (hcnt_zero) begin
                    hcnt_load = 1'b1;
                    if (spi_sck) begin
                        sck_fall = 1'b1;
                        if (bit_cnt == 5'd31) begin
                            word_done = 1'b1;
                            state_d   = ctrl_keep_cs ? ST_IDLE : ST_HOLD;
                        end
                    end else begin
                        sck_rise = 1'b1;
                    end
                end else begin
                    hcnt_dec = 1'b1;
                end
            end

            ST_HOLD: begin
                if (hcnt_zero) begin
                    cs_release = 1'b1;
                    hcnt_load  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    hcnt_dec = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // SPI datapath: half-period timer, pins, shift registers and bit counter.
    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            hcnt      <= '0;
            frame_div <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            spi_sck   <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_copi  <= 1'b0;
        end else begin
            // The divider is latched at frame start so mid-frame CTRL writes
            // cannot change the SCK rate of a word in flight.
            if (start_frame) begin
                frame_div <= ctrl_div;
                hcnt      <= ctrl_div;
            end else if (hcnt_load) begin
                hcnt <= frame_div;
            end else if (hcnt_dec) begin
                hcnt <= hcnt - 1'b1;
            end

            if (tx_accept) begin
                tx_sr <= wbs_dat_i & wmask;
            end else if (sck_fall) begin
                tx_sr <= {tx_sr[30:0], 1'b0};
            end

            if (start_frame) begin
                spi_cs_n <= 1'b0;
                spi_copi <= tx_sr[31];
                bit_cnt  <= '0;
            end else if (cs_release) begin
                spi_cs_n <= 1'b1;
            end

            if (sck_rise) begin
                spi_sck <= 1'b1;
                rx_sr   <= {rx_sr[30:0], rx_in};
            end

            if (sck_fall) begin
                spi_sck  <= 1'b0;
                spi_copi <= tx_sr[30];
                bit_cnt  <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rapcore_spi_controller.sv
// tb_rapcore_spi_controller
//   Directed bench for rapcore_spi_controller: register access, SPI framing,
//   timing, chained frames, overrun, loopback (when SPI_LOOPBACK_EN) and
//   mid-word reset. A simple mode-0 responder drives spi_cipo.

module tb_rapcore_spi_controller;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_TXDATA = 32'h3000_0004;
    localparam logic [31:0] A_RXDATA = 32'h3000_0008;
    localparam logic [31:0] A_STATUS = 32'h3000_000C;
    localparam logic [31:0] A_BAD    = 32'h3000_0010;

    logic        wb_clk_i;
    logic        resetn;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_copi;
    logic        spi_cipo;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rapcore_spi_controller dut (
        .wb_clk_i  (wb_clk_i),
        .resetn    (resetn),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .spi_sck   (spi_sck),
        .spi_cs_n  (spi_cs_n),
        .spi_copi  (spi_copi),
        .spi_cipo  (spi_cipo),
        .busy      (busy)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // ------------------------------------------------------------------
    // SPI link monitor and mode-0 responder
    // ------------------------------------------------------------------
    logic [31:0] resp_word = 32'h0;
    logic [31:0] copi_sr   = 32'h0;
    int  rise_cnt    = 0;
    int  fall_cnt    = 0;
    int  cs_rise_cnt = 0;
    int  rise_at_cs  = 0;
    int  fall_at_cs  = 0;
    time t_cs_fall, t_cs_rise, t_first_rise, t_rise, t_rise_prev, t_last_fall;

    // Responder presents bit 31 when CS falls and the next bit on each SCK fall.
    assign spi_cipo = resp_word[31 - ((fall_cnt - fall_at_cs) & 31)];

    always @(negedge spi_cs_n) begin
        t_cs_fall  = $time;
        rise_at_cs = rise_cnt;
        fall_at_cs = fall_cnt;
    end

    always @(posedge spi_cs_n) begin
        t_cs_rise   = $time;
        cs_rise_cnt = cs_rise_cnt + 1;
    end

    always @(posedge spi_sck) begin
        if (rise_cnt == rise_at_cs) t_first_rise = $time;
        t_rise_prev = t_rise;
        t_rise      = $time;
        rise_cnt    = rise_cnt + 1;
        copi_sr     = {copi_sr[30:0], spi_copi};
    end

    always @(negedge spi_sck) begin
        t_last_fall = $time;
        fall_cnt    = fall_cnt + 1;
    end

    // ------------------------------------------------------------------
    // Checking and bus tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        rdat      = 32'hxxxx_xxxx;
        acked     = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        logic        a;
        wb_cycle(1'b1, adr, dat, sel, r, a);
        check("write_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic wb_read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        logic        a;
        wb_cycle(1'b0, adr, 32'h0, 4'hF, r, a);
        check(tag, r, exp);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000 && busy; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int rise_base;
    int csr_base;
    logic [31:0] r_dummy;
    logic        a_dummy;

    initial begin
        resetn    = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;

        // Reset values
        tick(3);
        check("rst_ack",  {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat",  wbs_dat_o, 32'd0);
        check("rst_sck",  {31'd0, spi_sck}, 32'd0);
        check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_copi", {31'd0, spi_copi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        tick(1);
        wb_read_chk("rst_ctrl",   A_CTRL,   32'h0000_0003);
        wb_read_chk("rst_status", A_STATUS, 32'h0000_0000);
        wb_read_chk("tx_reads_0", A_TXDATA, 32'h0000_0000);
        check("ack_one_cycle", {31'd0, wbs_ack_o}, 32'd1);
        tick(1);
        check("ack_dropped", {31'd0, wbs_ack_o}, 32'd0);
        wb_cycle(1'b0, A_BAD, 32'h0, 4'hF, r_dummy, a_dummy);
        check("undecoded_no_ack", {31'd0, a_dummy}, 32'd0);

        // div=0: H=1, SCK = clk/2
        wb_write(A_CTRL, 32'h0000_0000, 4'hF);
        resp_word = 32'h1234_5678;
        rise_base = rise_cnt;
        wb_write(A_TXDATA, 32'hA5C3_0F81, 4'hF);
        check("busy_on_ack", {31'd0, busy}, 32'd1);
        wait_idle("div0_done");
        tick(4);
        check("div0_copi",   copi_sr, 32'hA5C3_0F81);
        check("div0_rises",  32'(rise_cnt - rise_base), 32'd32);
        check("div0_setup",  32'(t_first_rise - t_cs_fall), 32'd10);
        check("div0_period", 32'(t_rise - t_rise_prev), 32'd20);
        check("div0_hold",   32'(t_cs_rise - t_last_fall), 32'd10);
        check("div0_cs_n",   {31'd0, spi_cs_n}, 32'd1);
        check("div0_sck",    {31'd0, spi_sck}, 32'd0);
        wb_read_chk("div0_rx",     A_RXDATA, 32'h1234_5678);
        wb_read_chk("div0_status", A_STATUS, 32'h0000_0002);

        // div=3: H=4, SCK period 8 clocks
        wb_write(A_CTRL, 32'h0000_0003, 4'hF);
        resp_word = 32'hCAFE_F00D;
        rise_base = rise_cnt;
        wb_write(A_TXDATA, 32'h0F0F_0F0F, 4'hF);
        wb_read_chk("div3_status_mid", A_STATUS, 32'h0000_0001);
        wb_read_chk("div3_rx_mid",     A_RXDATA, 32'h1234_5678);
        wait_idle("div3_done");
        tick(10);
        check("div3_copi",   copi_sr, 32'h0F0F_0F0F);
        check("div3_rises",  32'(rise_cnt - rise_base), 32'd32);
        check("div3_setup",  32'(t_first_rise - t_cs_fall), 32'd40);
        check("div3_period", 32'(t_rise - t_rise_prev), 32'd80);
        check("div3_hold",   32'(t_cs_rise - t_last_fall), 32'd40);
        wb_read_chk("div3_rx", A_RXDATA, 32'hCAFE_F00D);

        // Overrun: second TXDATA while busy is dropped
        rise_base = rise_cnt;
        wb_write(A_TXDATA, 32'h1357_9BDF, 4'hF);
        wb_write(A_TXDATA, 32'hFFFF_FFFF, 4'hF);
        wb_read_chk("ovr_status_mid", A_STATUS, 32'h0000_0005);
        wait_idle("ovr_done");
        tick(10);
        check("ovr_copi",  copi_sr, 32'h1357_9BDF);
        check("ovr_rises", 32'(rise_cnt - rise_base), 32'd32);
        wb_read_chk("ovr_status_end", A_STATUS, 32'h0000_0006);
        wb_write(A_STATUS, 32'h0000_0004, 4'hF);
        wb_read_chk("ovr_cleared", A_STATUS, 32'h0000_0002);
        wb_write(A_STATUS, 32'h0000_0002, 4'hF);
        wb_read_chk("done_cleared", A_STATUS, 32'h0000_0000);

        // Byte lane write: only byte 1 (keep_cs) changes, div stays 3
        wb_write(A_CTRL, 32'h0000_01FF, 4'b0010);
        wb_read_chk("ctrl_sel_byte1", A_CTRL, 32'h0000_0103);

        // keep_cs chaining: two words in one CS frame
        wb_write(A_CTRL, 32'h0000_0100, 4'hF);
        rise_base = rise_cnt;
        csr_base  = cs_rise_cnt;
        wb_write(A_TXDATA, 32'h0000_0001, 4'hF);
        wait_idle("chain_w1_done");
        wb_write(A_TXDATA, 32'h0000_0002, 4'hF);
        wait_idle("chain_w2_done");
        tick(10);
        check("chain_cs_low",   {31'd0, spi_cs_n}, 32'd0);
        check("chain_rises",    32'(rise_cnt - rise_base), 32'd64);
        check("chain_no_cs_up", 32'(cs_rise_cnt - csr_base), 32'd0);
        check("chain_copi_w2",  copi_sr, 32'h0000_0002);
        wb_write(A_CTRL, 32'h0000_0000, 4'hF);
        tick(5);
        check("chain_cs_release", {31'd0, spi_cs_n}, 32'd1);

`ifdef SPI_LOOPBACK_EN
        wb_write(A_CTRL, 32'h0000_0200, 4'hF);
        wb_read_chk("lpbk_ctrl", A_CTRL, 32'h0000_0200);
        resp_word = 32'h0000_0000;
        wb_write(A_TXDATA, 32'hDEAD_BEEF, 4'hF);
        wait_idle("lpbk_done");
        wb_read_chk("lpbk_rx", A_RXDATA, 32'hDEAD_BEEF);
`else
        wb_write(A_CTRL, 32'h0000_0200, 4'hF);
        wb_read_chk("no_lpbk_ctrl", A_CTRL, 32'h0000_0000);
`endif

        // Reset in the middle of a word
        wb_write(A_CTRL, 32'h0000_0003, 4'hF);
        tick(10);
        wb_write(A_TXDATA, 32'h1111_2222, 4'hF);
        tick(30);
        check("mid_busy",  {31'd0, busy}, 32'd1);
        check("mid_cs_n",  {31'd0, spi_cs_n}, 32'd0);
        resetn = 1'b0;
        tick(1);
        check("rst_mid_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_sck",  {31'd0, spi_sck}, 32'd0);
        resetn = 1'b1;
        tick(1);
        wb_read_chk("rst_mid_rx",     A_RXDATA, 32'h0000_0000);
        wb_read_chk("rst_mid_ctrl",   A_CTRL,   32'h0000_0003);
        wb_read_chk("rst_mid_status", A_STATUS, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
